// File: rtl/flatten_fc_pp_ctrl.sv
// Ping-pong input-buffer controller between a flattening layer and an FC CIM layer.
// Fills two banks from input beats and streams each full bank slice-by-slice into the CIM.
module flatten_fc_pp_ctrl #(
  parameter int DATA_SIZE      = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int INPUT_CHANNELS = 16,
  parameter int IMG_SIZE       = 784,
  parameter int XBAR_SIZE      = 128,
  parameter int BUS_WIDTH      = 16,
  localparam int TOTAL_ELEMS     = INPUT_CHANNELS * IMG_SIZE,
  localparam int V_CIM_TILES_OUT = (TOTAL_ELEMS + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int WORD_ELEMS      = BUS_WIDTH * V_CIM_TILES_OUT,
  localparam int ADDR_RAW        = (TOTAL_ELEMS + WORD_ELEMS - 1) / WORD_ELEMS,
  localparam int NUM_ADDR        = (ADDR_RAW < 1) ? 1 : ADDR_RAW,
  localparam int NUM_SLICES      = DATA_SIZE / BITS_PER_CYCLE,
  localparam int COUNT_WIDTH     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1,
  localparam int ADDR_WIDTH      = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  output logic                   o_ready,
  output logic                   o_wr_bank,
  output logic                   o_bank,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  input  logic                   i_cim_ready,
  output logic                   o_cim_we,
  output logic                   o_cim_start,
  input  logic                   i_func_ready,
  output logic                   o_func_start
);

  localparam int FILL_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [FILL_W-1:0]      LAST_BEAT  = FILL_W'(IMG_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(NUM_ADDR - 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_SLICE = COUNT_WIDTH'(NUM_SLICES - 1);

  typedef enum logic [2:0] {IDLE, CONSUME, START, WAIT, FUNC} state_t;

  state_t            state;
  logic [FILL_W-1:0] fill_cnt;
  logic [1:0]        full;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;
  logic              beat_ok;
  logic              beat_done;

  assign o_ready      = !full[o_wr_bank];
  assign beat_ok      = i_start && o_ready;
  assign beat_done    = beat_ok && (fill_cnt == LAST_BEAT);
  assign o_cim_start  = (state == START) && i_cim_ready;
  assign o_func_start = (state == FUNC) && i_func_ready;

  // Set and release always hit different banks, so both apply in one cycle.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    full_set[o_wr_bank] = beat_done;
    full_clr[o_bank]    = o_func_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt  <= '0;
      full      <= '0;
      o_wr_bank <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (beat_done) begin
        fill_cnt  <= '0;
        o_wr_bank <= ~o_wr_bank;
      end else if (beat_ok) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      o_addr   <= '0;
      o_count  <= '0;
      o_bank   <= 1'b0;
      o_cim_we <= 1'b0;
    end else begin
      o_cim_we <= 1'b0;
      case (state)
        IDLE: begin
          o_addr  <= '0;
          o_count <= '0;
          if (full[o_bank] && i_cim_ready) begin
            state    <= CONSUME;
            o_cim_we <= 1'b1;
          end
        end
        CONSUME: begin
          if (o_addr == LAST_ADDR) begin
            state <= START;
          end else begin
            o_addr   <= o_addr + 1'b1;
            o_cim_we <= 1'b1;
          end
        end
        START: begin
          o_addr <= '0;
          if (!i_cim_ready) state <= WAIT;
        end
        WAIT: begin
          if (i_cim_ready) begin
            if (o_count != LAST_SLICE) begin
              o_count  <= o_count + 1'b1;
              o_cim_we <= 1'b1;
              state    <= CONSUME;
            end else begin
              state <= FUNC;
            end
          end
        end
        FUNC: begin
          if (i_func_ready) begin
            o_bank  <= ~o_bank;
            o_count <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flatten_fc_pp_ctrl.sv
// Scoreboard bench: a cycle model of the fill side queues expected CIM words and
// func handoffs as beats are accepted; the monitor pops them as the DUT emits them.
module tb_flatten_fc_pp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, i_start, start2, i_func_ready, cim_hold;
  logic o_ready, o_wr_bank, o_bank, o_cim_we, o_cim_start, o_func_start;
  logic [1:0] o_count, o_addr;
  logic r2, wb2, b2, we2, cs2, fs2;
  logic [0:0] cnt2;
  logic [1:0] addr2;
  logic cim_rdy, cim_rdy2;
  int busy, busy2;

  int nerr = 0, nchk = 0;
  int fcount = 0, f2count = 0, wcount = 0;
  int q[$], fq[$], q2[$], fq2[$];
  logic [1:0] mfull, mfull2;
  logic mwr, mwr2;
  int mfill, mfill2;

  flatten_fc_pp_ctrl #(.DATA_SIZE(4), .BITS_PER_CYCLE(1), .INPUT_CHANNELS(2),
    .IMG_SIZE(4), .XBAR_SIZE(8), .BUS_WIDTH(2)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_ready(o_ready),
    .o_wr_bank(o_wr_bank), .o_bank(o_bank), .o_count(o_count), .o_addr(o_addr),
    .i_cim_ready(cim_rdy), .o_cim_we(o_cim_we), .o_cim_start(o_cim_start),
    .i_func_ready(i_func_ready), .o_func_start(o_func_start));

  flatten_fc_pp_ctrl #(.DATA_SIZE(4), .BITS_PER_CYCLE(2), .INPUT_CHANNELS(2),
    .IMG_SIZE(4), .XBAR_SIZE(8), .BUS_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_start(start2), .o_ready(r2),
    .o_wr_bank(wb2), .o_bank(b2), .o_count(cnt2), .o_addr(addr2),
    .i_cim_ready(cim_rdy2), .o_cim_we(we2), .o_cim_start(cs2),
    .i_func_ready(i_func_ready), .o_func_start(fs2));

  // CIM model: busy for 3 cycles after an accepted start.
  assign cim_rdy  = (busy == 0) && !cim_hold;
  assign cim_rdy2 = (busy2 == 0);
  always @(posedge clk or posedge rst)
    if (rst) busy <= 0;
    else if (o_cim_start) busy <= 3;
    else if (busy > 0) busy <= busy - 1;
  always @(posedge clk or posedge rst)
    if (rst) busy2 <= 0;
    else if (cs2) busy2 <= 3;
    else if (busy2 > 0) busy2 <= busy2 - 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int word(input int b, input int s, input int a);
    return b * 256 + s * 16 + a;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mfull = '0; mwr = 1'b0; mfill = 0; q.delete(); fq.delete();
      mfull2 = '0; mwr2 = 1'b0; mfill2 = 0; q2.delete(); fq2.delete();
    end else begin
      automatic logic acc  = !mfull[mwr];
      automatic logic acc2 = !mfull2[mwr2];
      chk("ready", o_ready, acc);
      chk("ready2", r2, acc2);
      if (o_cim_we) begin
        wcount++;
        if (q.size() == 0) chk("we_extra", 1, 0);
        else chk("we_word", word(int'(o_bank), int'(o_count), int'(o_addr)), q.pop_front());
      end
      if (o_func_start) begin
        fcount++;
        if (fq.size() == 0) chk("func_extra", 1, 0);
        else begin
          automatic int b = fq.pop_front();
          chk("func_bank", o_bank, b);
          mfull[b] = 1'b0;
        end
      end
      if (i_start && acc) begin
        mfill++;
        if (mfill == 4) begin
          mfill = 0;
          for (int s = 0; s < 4; s++)
            for (int a = 0; a < 4; a++) q.push_back(word(int'(mwr), s, a));
          fq.push_back(int'(mwr));
          mfull[mwr] = 1'b1;
          mwr = !mwr;
        end
      end
      if (we2) begin
        if (q2.size() == 0) chk("we2_extra", 1, 0);
        else chk("we2_word", word(int'(b2), int'(cnt2), int'(addr2)), q2.pop_front());
      end
      if (fs2) begin
        f2count++;
        if (fq2.size() == 0) chk("func2_extra", 1, 0);
        else begin
          automatic int b = fq2.pop_front();
          chk("func2_bank", b2, b);
          mfull2[b] = 1'b0;
        end
      end
      if (start2 && acc2) begin
        mfill2++;
        if (mfill2 == 4) begin
          mfill2 = 0;
          for (int s = 0; s < 2; s++)
            for (int a = 0; a < 4; a++) q2.push_back(word(int'(mwr2), s, a));
          fq2.push_back(int'(mwr2));
          mfull2[mwr2] = 1'b1;
          mwr2 = !mwr2;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic beats(input int n);
    i_start = 1'b1; step(n); i_start = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((q.size() + fq.size() + q2.size() + fq2.size()) != 0 && n < max) begin
      step(1); n++;
    end
    chk("drain", q.size() + fq.size() + q2.size() + fq2.size(), 0);
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_ready"}, o_ready, 1);
    chk({pfx, "_we"}, o_cim_we, 0);
    chk({pfx, "_cstart"}, o_cim_start, 0);
    chk({pfx, "_fstart"}, o_func_start, 0);
    chk({pfx, "_addr"}, o_addr, 0);
    chk({pfx, "_count"}, o_count, 0);
    chk({pfx, "_wrbank"}, o_wr_bank, 0);
    chk({pfx, "_bank"}, o_bank, 0);
    chk({pfx, "_wrbank2"}, wb2, 0);
  endtask

  initial begin
    int f0, w0, n;
    rst = 1'b1; i_start = 1'b0; start2 = 1'b0; i_func_ready = 1'b1; cim_hold = 1'b0;
    #1 chk_reset_outs("por");
    step(2); rst = 1'b0;

    // single inference
    f0 = fcount;
    beats(4);
    drain(300); step(3);
    chk("s1_func_cnt", fcount - f0, 1);
    chk("s1_bank_end", o_bank, 1);

    // ping-pong: both banks filled back-to-back, 9th beat dropped
    beats(8);
    chk("pp_full", o_ready, 0);
    beats(1);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_func_start && n < 300);
    chk("pp_func_seen", o_func_start, 1);
    chk("pp_ready_lo", o_ready, 0);
    @(negedge clk);
    chk("pp_ready_hi", o_ready, 1);
    drain(400); step(3);

    // func unit stalls at handoff
    i_func_ready = 1'b0;
    f0 = fcount;
    beats(4);
    n = 0;
    while (q.size() != 0 && n < 300) begin step(1); n++; end
    step(18);
    chk("stall_no_func", fcount - f0, 0);
    chk("stall_bank_held", o_bank, 1);
    i_func_ready = 1'b1;
    step(3);
    chk("stall_one_pulse", fcount - f0, 1);
    chk("stall_bank_rel", o_bank, 0);

    // CIM busy while a bank is waiting in IDLE
    cim_hold = 1'b1;
    w0 = wcount;
    beats(4);
    step(5);
    chk("hold_no_we", wcount - w0, 0);
    cim_hold = 1'b0;
    @(negedge clk); chk("hold_we_lo", o_cim_we, 0);
    @(negedge clk); chk("hold_we_go", o_cim_we, 1);
    drain(300); step(3);

    // two-bit slices
    f0 = f2count;
    start2 = 1'b1; step(4); start2 = 1'b0;
    drain(300); step(3);
    chk("bpc2_func_cnt", f2count - f0, 1);
    chk("bpc2_bank_end", b2, 1);

    // async reset in the middle of CONSUME
    beats(4);
    n = 0;
    do begin @(negedge clk); n++; end while (!(o_cim_we && o_addr == 2'd2) && n < 200);
    chk("rst_hit_addr2", o_addr, 2);
    #1 rst = 1'b1;
    #1 chk_reset_outs("mid");
    step(2); rst = 1'b0;
    f0 = fcount; w0 = wcount;
    beats(3);
    step(10);
    chk("rst_3beats_no_we", wcount - w0, 0);
    beats(1);
    drain(300); step(3);
    chk("rst_refill_func", fcount - f0, 1);
    chk("rst_refill_bank", o_bank, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/flatten_fc_pp_ctrl.md
# flatten_fc_pp_ctrl

Controller between a flattening layer and a fully-connected CIM layer. It accumulates IMG_SIZE input beats into one of two ping-pong input-buffer banks. It then streams the full bank into the CIM row buffer one bit-slice at a time (BITS_PER_CYCLE bits per slice), starts the CIM for each slice, and hands off to the function unit after the last slice. The second bank lets the previous layer keep producing while the CIM processes, and the slice width is configurable for multi-bit DACs.

## Interface
Parameters:
- DATA_SIZE, 8: activation bit width.
- BITS_PER_CYCLE, 1: bits applied per CIM run. Must divide DATA_SIZE.
- INPUT_CHANNELS, 16: channels of the flattened feature map.
- IMG_SIZE, 784: input beats (i_start pulses) per inference.
- XBAR_SIZE, 128: crossbar rows.
- BUS_WIDTH, 16: elements per ibuf word.
- V_CIM_TILES_OUT, derived: ceil(INPUT_CHANNELS*IMG_SIZE / XBAR_SIZE).
- NUM_ADDR, derived: ceil(INPUT_CHANNELS*IMG_SIZE / (BUS_WIDTH*V_CIM_TILES_OUT)), minimum 1.
- NUM_SLICES, derived: DATA_SIZE/BITS_PER_CYCLE.
- COUNT_WIDTH, derived: max(1, clog2(NUM_SLICES)).
- ADDR_WIDTH, derived: max(1, clog2(NUM_ADDR)).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one input beat from the previous layer, counted only when o_ready=1
- o_ready  out  1  at least one bank is free
- o_wr_bank  out  1  bank currently being filled
- o_bank  out  1  bank currently being consumed (ibuf read address MSB)
- o_count  out  COUNT_WIDTH  current bit-slice index
- o_addr  out  ADDR_WIDTH  ibuf/CIM word address
- i_cim_ready  in  1  CIM idle
- o_cim_we  out  1  CIM row-buffer write strobe
- o_cim_start  out  1  CIM start request
- i_func_ready  in  1  function unit idle
- o_func_start  out  1  function unit start pulse

## Operation
- Reset state: fill count 0, both banks empty, wr_bank=0, o_bank=0, slice count 0, addr 0, FSM IDLE.
- Output values under reset: o_ready=1, o_cim_we=0, o_cim_start=0, o_func_start=0, o_addr=0, o_count=0, o_wr_bank=0, o_bank=0.
- Fill side (independent of the FSM):
  - An i_start with o_ready=1 increments the fill count.
  - On the IMG_SIZE-th beat: the fill count clears, bank[wr_bank] is marked full, and wr_bank toggles.
  - o_ready = !full[wr_bank].
  - An i_start while o_ready=0 is dropped; no count change.
- Consume FSM, states IDLE, CONSUME, START, WAIT, FUNC:
  - IDLE: addr=0, slice=0. If full[o_bank] and i_cim_ready, go to CONSUME.
  - CONSUME: o_cim_we=1, o_addr = 0..NUM_ADDR-1, one word per cycle. After addr NUM_ADDR-1, go to START; addr holds its value.
  - START: addr=0. o_cim_start = i_cim_ready. When i_cim_ready=0, go to WAIT.
  - WAIT: when i_cim_ready=1:
    - if slice < NUM_SLICES-1: slice+1, go to CONSUME.
    - else: go to FUNC.
  - FUNC: o_func_start = i_func_ready. When i_func_ready=1:
    - full[o_bank] clears.
    - o_bank toggles.
    - slice clears.
    - go to IDLE.
- All FSM outputs other than those listed in the state descriptions are 0.
- Simultaneous events:
  - A fill completing in the same cycle a bank is released applies both updates.
  - A fill never targets a full bank, so there is no overflow.
- An illegal state encoding recovers to IDLE.

## Timing
- The i_start that completes a bank registers full at the next edge. With the FSM in IDLE and i_cim_ready=1, the first o_cim_we occurs in the 2nd cycle after that beat.
- Each slice costs NUM_ADDR we-cycles, plus ≥1 START cycle, plus the CIM busy time.
- o_func_start is a single-cycle pulse, asserted the cycle after the last-slice WAIT sees ready, provided i_func_ready=1.
- A bank is released on the o_func_start cycle. o_ready can rise in the following cycle.
- Back-to-back inferences: with bank B full, the FSM leaves IDLE one cycle after the FUNC exit.
- Reset is asynchronous. Asserting rst mid-operation forces all outputs to their reset values immediately, discarding both banks.

## Test plan
Use DATA_SIZE=4, BITS_PER_CYCLE=1, INPUT_CHANNELS=2, IMG_SIZE=4, XBAR_SIZE=8, BUS_WIDTH=2, giving NUM_ADDR=4 and NUM_SLICES=4.
- Single inference, CIM model busy 3 cycles after start, func always ready. Required: 4 beats, then 4 slices; each slice shows o_cim_we on addr 0,1,2,3 with o_count 0..3. Exactly one o_func_start. o_bank ends at 1.
- Ping-pong: 8 consecutive beats. Required: o_ready stays 1 through beat 8, then falls to 0. A 9th i_start is dropped. o_ready rises the cycle after the first o_func_start; the second inference follows with o_bank=1.
- Func stall: i_func_ready=0 for 10 cycles at FUNC. Required: o_func_start=0 and the bank is held until ready, then a 1-cycle pulse.
- CIM not ready in IDLE: bank full, i_cim_ready=0 for 5 cycles. Required: no o_cim_we until ready, then CONSUME begins 1 cycle later.
- BITS_PER_CYCLE=2. Required: 2 slices per inference, o_count 0,1.
- Reset mid-CONSUME (addr=2). Required: all outputs at reset values immediately. After release, o_ready=1 and 4 fresh beats are needed to restart.
